// File: rtl/nibble_serial_add_sub.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice per cycle, LSB nibble first.
// Optional signed-overflow flag port enabled by defining OVERFLOW_FLAG_EN.
module nibble_serial_add_sub #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              w,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic              c_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic              ovf
`endif
);

    localparam int NIB   = DATA_W / 4;
    localparam int CNT_W = $clog2(NIB);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    nib_cnt;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;      // addend already inverted for subtraction
    logic                carry_q;
    logic [DATA_W-5:0]   acc_q;    // completed low nibbles, newest on top
    logic [3:0]          nib_s;
    logic                nib_c;

    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign {nib_c, nib_s} = cla4(a_q[3:0], b_q[3:0], carry_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            nib_cnt <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (state)
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    carry_q <= nib_c;
                    acc_q   <= {nib_s, acc_q[DATA_W-5:4]};
                    nib_cnt <= nib_cnt + CNT_W'(1);
                    if (nib_cnt == CNT_W'(NIB - 1)) begin
                        // Top nibble: publish the full result in one shot.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= {nib_s, acc_q};
                        c_out <= nib_c;
`ifdef OVERFLOW_FLAG_EN
                        ovf   <= (a_q[3] == b_q[3]) && (nib_s[3] != a_q[3]);
`endif
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        state   <= RUN;
                        nib_cnt <= '0;
                        a_q     <= a;
                        b_q     <= b ^ {DATA_W{w}};
                        carry_q <= w;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_sub.sv
// Bench for nibble_serial_add_sub: directed cases plus randomized operations
// against an arithmetic reference model. Define OVERFLOW_FLAG_EN to cover ovf.
module tb_nibble_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        w = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        c_out;
`ifdef OVERFLOW_FLAG_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_add_sub #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .w     (w),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [32:0] model_res(input logic [31:0] x, input logic [31:0] y,
                                              input logic m);
        longint unsigned ux = longint'(x);
        longint unsigned uy = longint'(y);
        logic [31:0] r;
        logic        c;
        if (m) begin
            r = 32'(ux - uy);
            c = (ux >= uy);
        end else begin
            r = 32'(ux + uy);
            c = ((ux + uy) >= 64'h1_0000_0000);
        end
        return {c, r};
    endfunction

    function automatic logic model_ovf(input logic [31:0] x, input logic [31:0] y,
                                       input logic m);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r  = m ? (sx - sy) : (sx + sy);
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Launch one operation from idle; report latency to done and busy cycles.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic m,
                         output int lat, output int bcnt);
        a = x; b = y; w = m; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 32'h1234; b = 32'h1;
        tick(); tick();
        n_cmp++;
        if ({busy, done, sum, c_out} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%0b done=%0b sum=%h c_out=%0b, expected all 0",
                     busy, done, sum, c_out);
        end
`ifdef OVERFLOW_FLAG_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %0b expected 0", ovf);
        end
`endif
        start = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] va [3] = '{32'h0000_0001, 32'd5, 32'd3};
        logic [31:0] vb [3] = '{32'hFFFF_FFFF, 32'd3, 32'd5};
        logic        vw [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] es [3] = '{32'h0000_0000, 32'h0000_0002, 32'hFFFF_FFFE};
        logic        ec [3] = '{1'b1, 1'b1, 1'b0};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vw[i], lat, bcnt);
            n_cmp++;
            if (lat !== 8 || bcnt !== 8 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed_timing[%0d]: latency=%0d busy_cycles=%0d busy=%0b, expected 8/8/0",
                         i, lat, bcnt, busy);
            end
            n_cmp++;
            if (sum !== es[i] || c_out !== ec[i]) begin
                n_err++;
                $display("FAIL directed_result[%0d]: sum=%h c_out=%0b, expected %h/%0b",
                         i, sum, c_out, es[i], ec[i]);
            end
            tick();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed_pulse[%0d]: done=%0b busy=%0b after pulse, expected 0/0",
                         i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [6] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                                    32'h1, 32'h0000_FFFF};
        int lat, bcnt;
        logic [31:0] x, y;
        logic        m;
        logic [32:0] exp_r;
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            m = 1'($urandom_range(0, 1));
            exp_r = model_res(x, y, m);
            do_op(x, y, m, lat, bcnt);
            n_cmp++;
            if (lat !== 8 || {c_out, sum} !== exp_r) begin
                n_err++;
                $display("FAIL random[%0d]: %h %s %h -> sum=%h c_out=%0b lat=%0d, expected %h/%0b/8",
                         i, x, m ? "-" : "+", y, sum, c_out, lat, exp_r[31:0], exp_r[32]);
            end
`ifdef OVERFLOW_FLAG_EN
            n_cmp++;
            if (ovf !== model_ovf(x, y, m)) begin
                n_err++;
                $display("FAIL random_ovf[%0d]: got %0b expected %0b", i, ovf, model_ovf(x, y, m));
            end
`endif
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        logic [31:0] seen = 32'hDEAD_BEEF;
        a = 32'd1; b = 32'd1; w = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 32'hFF; b = 32'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                pulses++;
                seen = sum;
            end
            tick();
        end
        n_cmp++;
        if (pulses !== 1 || seen !== 32'd2 || sum !== 32'd2) begin
            n_err++;
            $display("FAIL ignore_start: pulses=%0d sum=%h, expected 1 pulse with sum 00000002",
                     pulses, seen);
        end
    endtask

    task automatic test_reset_midrun();
        int pulses = 0;
        int lat, bcnt;
        a = $urandom | 32'h1; b = $urandom; w = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 32'd0 || c_out !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset: busy=%0b done=%0b sum=%h c_out=%0b, expected 0/0/0/0",
                     busy, done, sum, c_out);
        end
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL midrun_no_done: got %0d done pulses, expected 0", pulses);
        end
        do_op(32'd2, 32'd2, 1'b0, lat, bcnt);
        n_cmp++;
        if (lat !== 8 || sum !== 32'd4) begin
            n_err++;
            $display("FAIL midrun_restart: sum=%h lat=%0d, expected 00000004/8", sum, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] x = $urandom;
        logic [31:0] y = $urandom;
        logic [32:0] exp_r = model_res(x, y, 1'b1);
        int last = -1;
        int pulses = 0;
        int bad_gap = 0;
        int bad_sum = 0;
        a = x; b = y; w = 1'b1; start = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (done) begin
                if (last >= 0 && (t - last) != 9) bad_gap++;
                last = t;
                pulses++;
            end
            if (pulses > 0 && {c_out, sum} !== exp_r) bad_sum++;
            if (pulses > 0 && !done && !busy) bad_gap++;
        end
        start = 1'b0;
        n_cmp++;
        if (pulses !== 4 || bad_gap !== 0) begin
            n_err++;
            $display("FAIL b2b_cadence: pulses=%0d gap_errors=%0d, expected 4 pulses 9 cycles apart",
                     pulses, bad_gap);
        end
        n_cmp++;
        if (bad_sum !== 0) begin
            n_err++;
            $display("FAIL b2b_hold: %0d cycles with sum/c_out=%h/%0b, expected %h/%0b",
                     bad_sum, sum, c_out, exp_r[31:0], exp_r[32]);
        end
        repeat (12) tick();
    endtask

`ifdef OVERFLOW_FLAG_EN
    task automatic test_overflow();
        logic [31:0] va [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5};
        logic [31:0] vb [3] = '{32'd1, 32'd1, 32'd3};
        logic        vw [3] = '{1'b0, 1'b1, 1'b1};
        logic        eo [3] = '{1'b1, 1'b1, 1'b0};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vw[i], lat, bcnt);
            n_cmp++;
            if (ovf !== eo[i]) begin
                n_err++;
                $display("FAIL overflow[%0d]: got %0b expected %0b", i, ovf, eo[i]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
`ifdef OVERFLOW_FLAG_EN
        test_overflow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_sub.md
NIBBLE_SERIAL_ADD_SUB -- requirements
Module: nibble_serial_add_sub

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled on the rising edge.
REQ-005 a  input  DATA_W  minuend/augend.
REQ-006 b  input  DATA_W  subtrahend/addend.
REQ-007 w  input  1  mode: 0 = add (a+b), 1 = subtract (a-b, two's complement via b XOR w with carry-in w).
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking the cycle in which a new result first appears.
REQ-010 sum  output  DATA_W  result.
REQ-011 c_out  output  1  carry out of the MSB; in subtract mode, 1 = no borrow (a >= b unsigned).
REQ-012 ovf  output  1  signed overflow; present only when OVERFLOW_FLAG_EN is defined.

Function
REQ-013 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after the last nibble; DONE->IDLE after one cycle unless start is high, in which case DONE->RUN.
REQ-014 start SHALL be accepted only in IDLE or DONE; on acceptance a, b, w SHALL be captured and the carry register loaded with w.
REQ-015 start during RUN SHALL be ignored, and the in-flight operands SHALL NOT change.
REQ-016 In RUN, exactly one 4-bit nibble SHALL be processed per cycle, LSB nibble first, using carry-lookahead logic within the nibble and the registered carry between nibbles.
REQ-017 Latency: start sampled at edge 0 SHALL produce the nibble-i result at edge i+1, and the transition to DONE at edge DATA_W/4 (8 cycles for 32 bits).
REQ-018 busy SHALL be high exactly while in RUN.
REQ-019 done SHALL be high exactly while in DONE.
REQ-020 sum, c_out and ovf SHALL be registered and updated only on the edge entering DONE.
REQ-021 sum, c_out and ovf SHALL hold their values until the next entry into DONE; partial results SHALL never be visible on sum.
REQ-022 Arithmetic SHALL be modulo 2^DATA_W; wrap-around is not an error, and c_out reports it.
REQ-023 Back-to-back operation: start in the DONE cycle SHALL begin a new RUN with no idle cycle, and done SHALL still pulse for that DONE cycle.

Reset
REQ-024 rst_n low at a rising edge SHALL force IDLE and clear the operand and carry registers.
REQ-025 rst_n low at a rising edge SHALL also force busy=0, done=0, sum=0, c_out=0 and ovf=0.
REQ-026 Reset SHALL override start and any state, including mid-RUN; the aborted operation SHALL produce no done pulse.
REQ-027 The first start after rst_n returns high SHALL be accepted normally.

Configuration
REQ-028 Macro OVERFLOW_FLAG_EN defined: ovf port and logic SHALL exist.
REQ-029 With OVERFLOW_FLAG_EN, ovf SHALL be 1 when the two effective MSB operands (a, b XOR w) are equal and the sum MSB differs from them; otherwise ovf SHALL be 0.
REQ-030 Macro OVERFLOW_FLAG_EN undefined: the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 a=0x0000_0001, b=0xFFFF_FFFF, w=0, start at edge 0 -> at edge 8: done=1, sum=0x0000_0000, c_out=1; busy high for edges 1-8 only.
REQ-032 a=5, b=3, w=1 -> sum=0x0000_0002, c_out=1; then a=3, b=5, w=1 -> sum=0xFFFF_FFFE, c_out=0.
REQ-033 Start (a=1, b=1, w=0), then start with a=0xFF, b=0xFF at edge 3 -> the second start is ignored; sum=0x0000_0002; exactly one done pulse.
REQ-034 rst_n low at edge 4 of a running add -> edge 5 shows busy=0, sum=0, no done; a new start (a=2, b=2) then yields sum=4.
REQ-035 Start held high continuously with fixed operands -> done pulses every 9th cycle with no gap cycle and identical sum each time.
REQ-036 With OVERFLOW_FLAG_EN: 0x7FFF_FFFF+1 -> ovf=1; 0x8000_0000-1 -> ovf=1; 5-3 -> ovf=0.
